// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined N-input selector: size limits, skid-state encodings, clog2.
// The state encoding is {main_valid, skid_valid}.
package mux_pkg;

    localparam int NUM_IN_MAX = 16;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b10;
    localparam logic [1:0] TWO   = 2'b11;

    typedef enum logic [1:0] {
        S_EMPTY = EMPTY,
        S_ONE   = ONE,
        S_TWO   = TWO
    } skid_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_nsel.sv
// Combinational NUM_IN-input selector; selects at or beyond NUM_IN saturate to the last input.
module mux_nsel
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [WIDTH-1:0]        out,
    output logic [SEL_W-1:0]        eff_sel
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_IN - 1);

    always_comb begin
        eff_sel = (int'(in_sel) >= NUM_IN) ? LAST : in_sel;
        out     = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(eff_sel) == k) out = in_data[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/mux_pipe_n.sv
// Registered N-input selector with a two-entry skid buffer for the EX stage.
// Build option MUX_PIPE_SEL_ERR_EN adds the sticky out-of-range select flag sel_err.
module mux_pipe_n
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    input  logic                    err_clr
);

    if (NUM_IN < 2 || NUM_IN > NUM_IN_MAX || SEL_W < clog2(NUM_IN)) begin : g_bad_params
        $error("mux_pipe_n: illegal NUM_IN/SEL_W combination");
    end

    logic [WIDTH-1:0] sel_data;
    logic [SEL_W-1:0] sel_eff;

    mux_nsel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_nsel (
        .in_data (in_data),
        .in_sel  (in_sel),
        .out     (sel_data),
        .eff_sel (sel_eff)
    );

    // Handshake: a side transfers on a rising edge where its valid and ready are both 1;
    // valid never waits on ready, and in_ready depends only on registered state.
    skid_state_e      state;
    skid_state_e      state_next;
    logic             main_valid;
    logic             skid_valid;
    logic             in_fire;
    logic             out_fire;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] main_sel;
    logic [SEL_W-1:0] skid_sel;

    // The unreachable {0,1} encoding decodes as empty.
    assign skid_valid = (state == S_TWO);
    assign main_valid = (state == S_ONE) || (state == S_TWO);
    assign in_ready   = !skid_valid;
    assign out_valid  = main_valid;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign out_data   = main_data;
    assign out_sel    = main_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            S_ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_next = S_TWO;
                    load_skid  = 1'b1;
                end else if (out_fire) begin
                    state_next = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_fire) begin
                    state_next     = S_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                if (in_fire) begin
                    state_next   = S_ONE;
                    load_main_in = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            main_sel  <= '0;
            skid_data <= '0;
            skid_sel  <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= sel_data;
                main_sel  <= sel_eff;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_sel  <= skid_sel;
            end
            if (load_skid) begin
                skid_data <= sel_data;
                skid_sel  <= sel_eff;
            end else if (load_main_skid) begin
                skid_data <= '0;
                skid_sel  <= '0;
            end
        end
    end

`ifdef MUX_PIPE_SEL_ERR_EN
    // Saturation changed the select exactly when the raw select was out of range.
    logic sel_bad;
    logic err_q;

    assign sel_bad = (sel_eff != in_sel);
    assign sel_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    err_q <= 1'b0;
        else if (in_fire && sel_bad)   err_q <= 1'b1;
        else if (err_clr)              err_q <= 1'b0;
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign sel_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: three instances (4x32, 3x8 saturating, 16x8) checked against a queue model.
// Covers both builds of MUX_PIPE_SEL_ERR_EN.
module tb_mux_pipe_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: NUM_IN=4, WIDTH=32, SEL_W=2
    logic [127:0] a_data = '0;
    logic [1:0]   a_sel = '0, a_osel;
    logic         a_valid = 1'b0, a_ready, a_ovalid, a_oready = 1'b0, a_err, a_clr = 1'b0;
    logic [31:0]  a_odata;
    // Instance B: NUM_IN=3, WIDTH=8, SEL_W=2
    logic [23:0]  b_data = '0;
    logic [1:0]   b_sel = '0, b_osel;
    logic         b_valid = 1'b0, b_ready, b_ovalid, b_oready = 1'b0, b_err, b_clr = 1'b0;
    logic [7:0]   b_odata;
    // Instance C: NUM_IN=16, WIDTH=8, SEL_W=4
    logic [127:0] c_data = '0;
    logic [3:0]   c_sel = '0, c_osel;
    logic         c_valid = 1'b0, c_ready, c_ovalid, c_oready = 1'b0, c_err, c_clr = 1'b0;
    logic [7:0]   c_odata;

    mux_pipe_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
        .in_ready(a_ready), .out_data(a_odata), .out_sel(a_osel), .out_valid(a_ovalid),
        .out_ready(a_oready), .sel_err(a_err), .err_clr(a_clr)
    );
    mux_pipe_n #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
        .in_ready(b_ready), .out_data(b_odata), .out_sel(b_osel), .out_valid(b_ovalid),
        .out_ready(b_oready), .sel_err(b_err), .err_clr(b_clr)
    );
    mux_pipe_n #(.WIDTH(8), .NUM_IN(16), .SEL_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_sel(c_sel), .in_valid(c_valid),
        .in_ready(c_ready), .out_data(c_odata), .out_sel(c_osel), .out_valid(c_ovalid),
        .out_ready(c_oready), .sel_err(c_err), .err_clr(c_clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: each accepted item is {min(sel, NUM_IN-1), input[that index]}; outputs leave in order.
    function automatic logic [33:0] a_pick(input logic [127:0] d, input logic [1:0] s);
        logic [127:0] t;
        t = d >> (int'(s) * 32);
        return {s, t[31:0]};
    endfunction

    function automatic logic [9:0] b_pick(input logic [23:0] d, input logic [1:0] s);
        int e;
        logic [23:0] t;
        e = (int'(s) > 2) ? 2 : int'(s);
        t = d >> (e * 8);
        return {2'(e), t[7:0]};
    endfunction

    function automatic logic [11:0] c_pick(input logic [127:0] d, input logic [3:0] s);
        logic [127:0] t;
        t = d >> (int'(s) * 8);
        return {s, t[7:0]};
    endfunction

    logic [33:0] a_q[$];
    logic [9:0]  b_q[$];
    logic [11:0] c_q[$];
    logic        b_err_m = 1'b0;
    int          a_dut_out = 0, b_dut_out = 0, c_dut_out = 0, b_in_cnt = 0, c_in_cnt = 0;
    bit          fi, fo;

    // Compare process: outputs are sampled on the falling edge, then the model advances
    // by the transfers that the next rising edge will perform.
    always @(negedge clk) begin
        if (!rst_n) begin
            a_q.delete();
            b_q.delete();
            c_q.delete();
            b_err_m = 1'b0;
            check("rst_a_ovalid", a_ovalid, 0);
            check("rst_a_ready", a_ready, 1);
            check("rst_a_odata", a_odata, 0);
            check("rst_a_osel", a_osel, 0);
            check("rst_b_ovalid", b_ovalid, 0);
            check("rst_b_err", b_err, 0);
            check("rst_c_ovalid", c_ovalid, 0);
        end else begin
            check("a_ovalid", a_ovalid, a_q.size() != 0);
            check("a_ready", a_ready, a_q.size() < 2);
            if (a_q.size() != 0) check("a_out", {a_osel, a_odata}, a_q[0]);
            check("a_err", a_err, 0);
            a_dut_out += int'(a_ovalid && a_oready);
            fo = (a_q.size() != 0) && a_oready;
            fi = a_valid && (a_q.size() < 2);
            if (fo) void'(a_q.pop_front());
            if (fi) a_q.push_back(a_pick(a_data, a_sel));

            check("b_ovalid", b_ovalid, b_q.size() != 0);
            check("b_ready", b_ready, b_q.size() < 2);
            if (b_q.size() != 0) check("b_out", {b_osel, b_odata}, b_q[0]);
            check("b_err", b_err, b_err_m);
            b_dut_out += int'(b_ovalid && b_oready);
            fo = (b_q.size() != 0) && b_oready;
            fi = b_valid && (b_q.size() < 2);
            if (fo) void'(b_q.pop_front());
            if (fi) begin
                b_q.push_back(b_pick(b_data, b_sel));
                b_in_cnt++;
            end
`ifdef MUX_PIPE_SEL_ERR_EN
            if (fi && b_sel >= 2'd3) b_err_m = 1'b1;
            else if (b_clr)          b_err_m = 1'b0;
`endif

            check("c_ovalid", c_ovalid, c_q.size() != 0);
            check("c_ready", c_ready, c_q.size() < 2);
            if (c_q.size() != 0) check("c_out", {c_osel, c_odata}, c_q[0]);
            check("c_err", c_err, 0);
            c_dut_out += int'(c_ovalid && c_oready);
            fo = (c_q.size() != 0) && c_oready;
            fi = c_valid && (c_q.size() < 2);
            if (fo) void'(c_q.pop_front());
            if (fi) begin
                c_q.push_back(c_pick(c_data, c_sel));
                c_in_cnt++;
            end
        end
    end

    int stream_base;

    initial begin
        // Reset and basic transfer
        repeat (3) step();
        check("lit_rst_ready", a_ready, 1);
        rst_n = 1'b1;
        a_data = {32'h44, 32'h33, 32'h22, 32'h11};
        a_sel = 2'd2; a_valid = 1'b1; a_oready = 1'b1;
        step();
        a_valid = 1'b0;
        check("lit_basic_ovalid", a_ovalid, 1);
        check("lit_basic_data", a_odata, 32'h33);
        check("lit_basic_sel", a_osel, 2);
        check("lit_basic_ready", a_ready, 1);
        step();
        check("lit_basic_drain", a_ovalid, 0);

        // Back-pressure: two accepted, third refused, then drained in order
        a_oready = 1'b0; a_valid = 1'b1;
        a_sel = 2'd0; step();
        a_sel = 2'd1; step();
        a_sel = 2'd3; step();
        check("lit_bp_ready", a_ready, 0);
        check("lit_bp_hold", a_odata, 32'h11);
        a_oready = 1'b1; step();
        check("lit_bp_second", a_odata, 32'h22);
        step();
        check("lit_bp_third", a_odata, 32'h44);
        check("lit_bp_third_sel", a_osel, 3);
        a_valid = 1'b0; step();
        check("lit_bp_empty", a_ovalid, 0);

        // Saturation on the 3-input instance
        b_data = 24'hC3B2A1; b_sel = 2'd3; b_valid = 1'b1; b_oready = 1'b1;
        step();
        b_valid = 1'b0;
        check("lit_sat_data", b_odata, 8'hC3);
        check("lit_sat_sel", b_osel, 2);
`ifdef MUX_PIPE_SEL_ERR_EN
        check("lit_err_set", b_err, 1);
        step();
        check("lit_err_sticky", b_err, 1);
        b_clr = 1'b1; b_valid = 1'b1; b_sel = 2'd3; step();
        b_valid = 1'b0;
        check("lit_err_set_wins", b_err, 1);
        step();
        b_clr = 1'b0;
        check("lit_err_clear", b_err, 0);
`else
        check("lit_err_tied", b_err, 0);
        b_clr = 1'b1; step(); b_clr = 1'b0;
        check("lit_err_tied_clr", b_err, 0);
`endif
        step();

        // Streaming: 100 back-to-back transfers
        stream_base = a_dut_out;
        a_oready = 1'b1; a_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a_data = {$urandom, $urandom, $urandom, $urandom};
            a_sel = 2'($urandom_range(0, 3));
            step();
            check("lit_stream_ovalid", a_ovalid, 1);
        end
        a_valid = 1'b0;
        step();
        check("lit_stream_count", a_dut_out - stream_base, 100);

        // Mid-operation asynchronous reset while two entries are held
        a_oready = 1'b0; a_valid = 1'b1;
        a_sel = 2'd0; step();
        a_sel = 2'd1; step();
        a_valid = 1'b0;
        check("lit_mid_full", a_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("lit_mid_ovalid", a_ovalid, 0);
        check("lit_mid_ready", a_ready, 1);
        step();
        rst_n = 1'b1;
        a_data = {32'h88, 32'h77, 32'h66, 32'h55};
        a_sel = 2'd1; a_valid = 1'b1; a_oready = 1'b1;
        step();
        a_valid = 1'b0;
        check("lit_mid_first", a_odata, 32'h66);
        check("lit_mid_first_sel", a_osel, 1);
        step();

        // Random traffic on the 16-input and 3-input instances
        for (int i = 0; i < 10000; i++) begin
            c_valid = 1'($urandom_range(0, 1));
            c_oready = 1'($urandom_range(0, 1));
            c_sel = 4'($urandom_range(0, 15));
            c_data = {$urandom, $urandom, $urandom, $urandom};
            b_valid = 1'($urandom_range(0, 1));
            b_oready = 1'($urandom_range(0, 1));
            b_sel = 2'($urandom_range(0, 3));
            b_data = 24'($urandom);
            b_clr = ($urandom_range(0, 9) == 0);
            step();
        end
        c_valid = 1'b0; c_oready = 1'b1;
        b_valid = 1'b0; b_oready = 1'b1; b_clr = 1'b0;
        repeat (4) step();
        check("lit_c_no_loss", c_dut_out, c_in_cnt);
        check("lit_b_no_loss", b_dut_out - 3, b_in_cnt - 3);
        check("lit_c_empty", c_ovalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_pipe_n.md
Name: mux_pipe_n

Overview:
- Parametrised N-input selector for the EX stage. Successor to the fixed 2/3/4/5-input combinational muxes.
- Muxes one of NUM_IN WIDTH-bit inputs, selected by a binary index, into a registered output stage.
- Valid/ready handshake on both sides; a two-entry skid buffer allows full throughput with a registered in_ready path.
- Used where the operand/forwarding select must be retimed across a pipeline boundary.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of selectable inputs; legal range 2..16.
- SEL_W, 2, select width; must be ≥ clog2(NUM_IN); checked at elaboration.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  binary select, sampled with in_data.
- in_valid  input  1  upstream offers in_data/in_sel.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  selected data.
- out_sel  output  SEL_W  effective select used for out_data, after saturation.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  downstream accepts.
- sel_err  output  1  sticky out-of-range-select flag (see Optional Feature).
- err_clr  input  1  synchronous clear of sel_err.

Behaviour:
- Reset: asynchronous, active-low.
  - While rst_n=0: out_valid=0, out_data=0, out_sel=0, skid entry invalid and zeroed, sel_err=0; in_valid is ignored.
  - in_ready = !skid_valid, so it reads 1 during and after reset.
  - Reset asserted mid-transfer discards both entries; no partial output.
- Select rule: effective select = min(in_sel, NUM_IN-1).
  - Any in_sel ≥ NUM_IN saturates to the last input. This is the same rule as the existing fixed-input muxes.
  - The mux is evaluated at acceptance, so data is captured already selected.
- Handshakes:
  - in fire = in_valid & in_ready.
  - out fire = out_valid & out_ready.
  - Latency: 1 cycle from in fire to out_valid.
  - Throughput: 1 transfer/cycle sustained while out_ready=1.
  - out_data/out_sel are held stable while out_valid=1 and out_ready=0.
- State (derived from main_valid and skid_valid):
  - EMPTY (0,0):
    - in fire → ONE, main ← selected.
  - ONE (1,0):
    - in fire & out fire → ONE, main ← new.
    - in fire & !out fire → TWO, skid ← new.
    - !in fire & out fire → EMPTY.
    - otherwise hold.
  - TWO (1,1): in_ready=0.
    - out fire → ONE, main ← skid, skid cleared.
    - otherwise hold.
- Ordering: strict FIFO; no reordering or drops.
- Illegal state (0,1) is unreachable; the implementation treats it as EMPTY.
- out_valid = main_valid.

Optional Feature:
- Macro MUX_PIPE_SEL_ERR_EN.
- Defined:
  - sel_err sets on the cycle after an in fire with in_sel ≥ NUM_IN.
  - It stays set until err_clr=1 at a clock edge.
  - Simultaneous set and clear → set wins.
- Undefined: sel_err is tied 0, err_clr is ignored, and no error logic is synthesised.
- Saturation behaviour is identical in both builds.

Decomposition:
- Package mux_pkg:
  - clog2 function.
  - NUM_IN_MAX=16.
  - Skid-state encodings EMPTY/ONE/TWO as localparams.
- Sub-module mux_nsel: combinational NUM_IN-input selector with saturation.
  - Parameters WIDTH, NUM_IN, SEL_W.
  - Ports in_data, in_sel, out, eff_sel.
  - Instantiated once at the input side, so both skid registers store selected data.

Test Plan:
- Reset/basic:
  - Stimulus: reset, NUM_IN=4, WIDTH=32, inputs {0x11,0x22,0x33,0x44}, in_sel=2, in_valid=1 for one cycle, out_ready=1.
  - Required: out_valid=1 one cycle later with out_data=0x33, out_sel=2; in_ready=1 throughout.
- Back-pressure:
  - Stimulus: out_ready=0, three consecutive offers with sel=0,1,3.
  - Required: first two accepted; in_ready=0 on the third cycle; out_data holds 0x11. Raising out_ready then yields 0x11, 0x22, 0x44 in order.
- Saturation:
  - Stimulus: NUM_IN=3, SEL_W=2, in_sel=3.
  - Required: out_data = input 2; out_sel=2. With MUX_PIPE_SEL_ERR_EN, sel_err=1 the cycle after acceptance and remains 1 until err_clr; err_clr and a new bad select in the same cycle leave sel_err=1.
- Streaming:
  - Stimulus: 100 back-to-back transfers with random sel and out_ready=1.
  - Required: 100 outputs on 100 consecutive cycles, matching a scoreboard.
- Mid-operation reset:
  - Stimulus: assert rst_n=0 asynchronously while in state TWO.
  - Required: out_valid=0 immediately; after release, no stale data emerges and the next input is output first.
- Random:
  - Stimulus: in_valid and out_ready each toggled at 50%, NUM_IN=16, WIDTH=8, 10k cycles.
  - Required: no loss, no duplication, order preserved; out_data stable whenever stalled.
